sseg_capture: RTL and testbench

Receive side of the four-digit multiplexed seven-segment interface. The block samples the anode/cathode lines of a scanned display, waits for each digit slot to settle, and decodes the segment pattern back to a 4-bit value. Once all four digits of a scan frame are captured, it publishes them as `one`/`ten`/`hunnid`/`thousand`. It sits at the board edge or in the loopback test harness, so a scanned display can be read back and checked against the values that drove it.

---
 rtl/sseg_pkg.sv | 13 +
 rtl/sseg_pattern_decode.sv | 19 +
 rtl/sseg_capture.sv | 104 ++++++++++
 tb/tb_sseg_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: segment patterns, anode indices and FSM states for the seven-segment capture block
package sseg_pkg;
  localparam int ONE      = 0;
  localparam int TEN      = 1;
  localparam int HUNNID   = 2;
  localparam int THOUSAND = 3;
  // active-high gfedcba patterns for hex digits, entry i encodes value i
  localparam logic [15:0][6:0] SEG_PAT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {SETTLING, HELD} state_e;
endpackage

// File: rtl/sseg_pattern_decode.sv
// sseg_pattern_decode: active-low cathodes back to a hex value, flagging unknown patterns
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] cat_i,
  output logic [3:0] value_o,
  output logic       err_o
);
  // search the segment table; no hit leaves value 0 with err set
  always_comb begin
    value_o = 4'd0;
    err_o   = 1'b1;
    for (int i = 0; i < 16; i++)
      if (~cat_i == SEG_PAT[i]) begin
        value_o = 4'(i);
        err_o   = 1'b0;
      end
  end
endmodule

// File: rtl/sseg_capture.sv
// sseg_capture: reads back a scanned four-digit seven-segment display into decoded frames
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seg_an,
  input  logic [6:0] seg_cat,
  output logic [3:0] one,
  output logic [3:0] ten,
  output logic [3:0] hunnid,
  output logic [3:0] thousand,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       stale
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [10:0] sync1_q, sync2_q, prev_q;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [3:0] seen_q, seen_d;
  logic stale_q, stale_d;
  state_e state_q;
  logic [3:0][3:0] stg_val_q, val_q;
  logic [3:0] stg_err_q, err_q;
  logic fv_q;
  logic match, at_limit, accept, publish, timeout;
  logic [3:0] dec_val;
  logic dec_err;

  sseg_pattern_decode u_dec (
    .cat_i   (sync2_q[6:0]),
    .value_o (dec_val),
    .err_o   (dec_err)
  );

  assign match    = sync2_q == prev_q;
  assign at_limit = match && dwell_q == CW'(SETTLE_CYCLES - 1);
  assign accept   = state_q == SETTLING && at_limit && $onehot(~sync2_q[10:7]);
  assign publish  = seen_q == 4'hF;
  assign timeout  = !accept && idle_q == TW'(TIMEOUT_CYCLES - 1);
  assign dwell_d  = !match ? '0 : dwell_q == CW'(SETTLE_CYCLES) ? dwell_q : dwell_q + 1'b1;
  assign idle_d   = accept ? '0 : idle_q == TW'(TIMEOUT_CYCLES) ? idle_q : idle_q + 1'b1;
  assign seen_d   = (publish || timeout ? 4'h0 : seen_q) | (accept ? ~sync2_q[10:7] : 4'h0);
  assign stale_d  = publish ? 1'b0 : timeout ? 1'b1 : stale_q;

  // synchronize pins, time the dwell and idle periods, track which digits arrived
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      dwell_q <= '0;
      idle_q  <= '0;
      seen_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      sync1_q <= {seg_an, seg_cat};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      dwell_q <= dwell_d;
      idle_q  <= idle_d;
      seen_q  <= seen_d;
      stale_q <= stale_d;
    end

  // SETTLING until the dwell limit is hit, then HELD until the pattern changes
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= SETTLING;
    else state_q <= state_q == SETTLING ? (at_limit ? HELD : SETTLING) : (match ? HELD : SETTLING);

  // stage accepted digits and copy the staging out when a frame completes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stg_val_q <= '0;
      stg_err_q <= '0;
      val_q     <= '0;
      err_q     <= '0;
      fv_q      <= 1'b0;
    end else begin
      fv_q <= publish;
      if (publish) begin
        val_q <= stg_val_q;
        err_q <= stg_err_q;
      end
      for (int i = 0; i < 4; i++)
        if (accept && !sync2_q[7 + i]) begin
          stg_val_q[i] <= dec_val;
          stg_err_q[i] <= dec_err;
        end
    end

  assign one         = val_q[ONE];
  assign ten         = val_q[TEN];
  assign hunnid      = val_q[HUNNID];
  assign thousand    = val_q[THOUSAND];
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;
endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: random and directed scans checked against a run-length reference model
module tb_sseg_capture;
  localparam int S = 4;
  localparam int T = 300;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] seg_an = 4'hF;
  logic [6:0] seg_cat = 7'h7F;
  logic [3:0] one, ten, hunnid, thousand, digit_err;
  logic frame_valid, stale;
  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [6:0] enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_out [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] m_sv [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] m_se = 4'd0, m_derr = 4'd0, m_seen = 4'd0;
  logic m_fv = 1'b0, m_stale = 1'b0;
  int n = 0, last = 0, runlen = 0;
  logic [10:0] runv = '1, pd1 = '1, pd2 = '1;
  logic pa1 = 1'b0, pa2 = 1'b0;

  sseg_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_an      (seg_an),
    .seg_cat     (seg_cat),
    .one         (one),
    .ten         (ten),
    .hunnid      (hunnid),
    .thousand    (thousand),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  // Reference: a pin value seen on S+1 consecutive edges becomes a digit two edges later.
  task automatic model_step();
    logic acc, pub;
    logic [10:0] d;
    int k;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_out[i] = 4'd0;
        m_sv[i] = 4'd0;
      end
      {m_se, m_derr, m_seen, m_fv, m_stale} = '0;
      last = n;
      runv = '1;
      runlen = 0;
      pa1 = 1'b0;
      pa2 = 1'b0;
      return;
    end
    n++;
    acc = pa2;
    d = pd2;
    pa2 = pa1;
    pd2 = pd1;
    if ({seg_an, seg_cat} == runv) runlen++;
    else begin
      runv = {seg_an, seg_cat};
      runlen = 1;
    end
    pa1 = runlen == S + 1 && $countones(~runv[10:7]) == 1;
    pd1 = runv;
    pub = m_seen == 4'hF;
    m_fv = pub;
    if (pub) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_sv[i];
      m_derr = m_se;
      m_seen = 4'h0;
      m_stale = 1'b0;
    end
    if (acc) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!d[7 + i]) k = i;
      m_sv[k] = 4'd0;
      m_se[k] = 1'b1;
      for (int i = 0; i < 16; i++)
        if (~d[6:0] == enc[i]) begin
          m_sv[k] = 4'(i);
          m_se[k] = 1'b0;
        end
      m_seen[k] = 1'b1;
      last = n;
    end else if (n - last == T) begin
      m_seen = 4'h0;
      if (!pub) m_stale = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    total++;
    if ({one, ten, hunnid, thousand, digit_err, frame_valid, stale} !==
        {m_out[0], m_out[1], m_out[2], m_out[3], m_derr, m_fv, m_stale}) begin
      bad++;
      $display("FAIL cycle t=%0t got o/t/h/th=%h%h%h%h err=%b fv=%b st=%b want %h%h%h%h err=%b fv=%b st=%b",
               $time, one, ten, hunnid, thousand, digit_err, frame_valid, stale,
               m_out[0], m_out[1], m_out[2], m_out[3], m_derr, m_fv, m_stale);
    end
    if (frame_valid) frames++;
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic hold(logic [3:0] an, logic [6:0] cat, int cyc);
    seg_an = an;
    seg_cat = cat;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(int a, int b, int c, int d, int dw);
    hold(4'hE, ~enc[a], dw);
    hold(4'hD, ~enc[b], dw);
    hold(4'hB, ~enc[c], dw);
    hold(4'h7, ~enc[d], dw);
  endtask

  initial begin
    int f0;
    int r;
    logic [3:0] an;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out", {one, ten, hunnid, thousand, digit_err}, 0);
    chk("reset_flags", {frame_valid, stale}, 0);
    hold(4'hF, 7'h7F, 10 * S);
    chk("idle_frames", frames, 0);
    scan(1, 2, 3, 4, 2 * S);
    scan(1, 2, 3, 4, 2 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("clean_frames", frames, 2);
    chk("clean_digits", {one, ten, hunnid, thousand}, 16'h1234);
    chk("clean_model", {m_out[0], m_out[1], m_out[2], m_out[3]}, 16'h1234);
    chk("clean_err", digit_err, 0);
    f0 = frames;
    for (int i = 0; i < 4; i++) begin
      an = 4'hF;
      an[i] = 1'b0;
      hold(an, ~enc[5 + i], S - 1);
      hold(4'hF, 7'h7F, S - 1);
      hold(an, ~enc[9 + i], S);
      hold(4'hF, 7'h7F, 1);
    end
    hold(4'b1100, ~enc[6], 3 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("short_frames", frames, f0);
    chk("short_hold", {one, ten, hunnid, thousand}, 16'h1234);
    hold(4'hE, ~enc[5], 2 * S);
    hold(4'hD, ~7'h01, 2 * S);
    hold(4'hB, ~enc[7], 2 * S);
    hold(4'h7, ~enc[8], 2 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("bad_frames", frames, f0 + 1);
    chk("bad_digits", {one, ten, hunnid, thousand}, 16'h5078);
    chk("bad_err", digit_err, 4'b0010);
    chk("bad_model_err", m_derr, 4'b0010);
    hold(4'hF, 7'h7F, T + 10);
    chk("stale_set", stale, 1);
    chk("stale_model", m_stale, 1);
    chk("stale_hold", {one, ten, hunnid, thousand}, 16'h5078);
    scan(9, 10, 11, 12, 2 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("resume_stale", stale, 0);
    chk("resume_digits", {one, ten, hunnid, thousand}, 16'h9ABC);
    hold(4'hE, ~enc[1], 2 * S);
    hold(4'hD, ~enc[2], 2 * S);
    seg_an = 4'hF;
    seg_cat = 7'h7F;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out", {one, ten, hunnid, thousand, digit_err, stale}, 0);
    f0 = frames;
    hold(4'hB, ~enc[3], 2 * S);
    hold(4'h7, ~enc[4], 2 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("rst_partial", frames, f0);
    hold(4'hE, ~enc[6], 2 * S);
    hold(4'hD, ~enc[7], 2 * S);
    hold(4'hF, 7'h7F, 2 * S);
    chk("rst_frames", frames, f0 + 1);
    chk("rst_digits", {one, ten, hunnid, thousand}, 16'h6734);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) hold(4'hF, 7'h7F, T + 20);
      else if (r < 4) hold(4'hF, 7'h7F, int'($urandom_range(1, 3 * S)));
      else if (r < 7) hold(4'($urandom_range(0, 15)), 7'($urandom), int'($urandom_range(1, 3 * S)));
      else begin
        an = 4'hF;
        an[$urandom_range(0, 3)] = 1'b0;
        hold(an, r < 11 ? 7'($urandom) : ~enc[$urandom_range(0, 15)], int'($urandom_range(1, 3 * S)));
      end
    end
    hold(4'hF, 7'h7F, 2 * S);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
